// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall codes, redirect targets and FSM state encodings.
// Imported by pipe_stall_enc and pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE  = 32'h0000000E;

    // Stall vector bit order: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb; 1 means hold.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } ctrl_state_e;

    // ERET returns to the saved EPC; every other exception enters the general vector.
    function automatic logic [31:0] redirect_target(input logic [31:0] exc_type,
                                                    input logic [31:0] epc);
        return (exc_type == ERET_CODE) ? epc : EXC_VECTOR;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// Combinational priority encoder from the four per-stage stall requests to the 6-bit stall code.
// The deepest requesting stage wins, since it must freeze everything upstream of it.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if_i,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       stallreq_mem_i,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
        end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end else if (stallreq_if_i) begin
            stall_o = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests and sequences exception/ERET redirects.
// Optional macro PIPE_CTRL_PERF_EN adds stall-cycle and flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        exc_valid_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
`endif
);

    ctrl_state_e state_q;
    logic        flush_q;
    logic        busy_q;
    logic [31:0] new_pc_q;
    logic [31:0] new_pc_d;
    logic [5:0]  enc_stall;
    logic        accept;

    pipe_stall_enc u_stall_enc (
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .stall_o        (enc_stall)
    );

    // A stalled MEM stage keeps its exception pending until the stall clears.
    assign accept   = (state_q == ST_RUN) && exc_valid_i && !stallreq_mem_i;
    assign new_pc_d = redirect_target(excepttype_i, epc_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            new_pc_q <= 32'h0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        state_q  <= ST_FLUSH;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        new_pc_q <= new_pc_d;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RECOVER;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                ST_RECOVER: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Requests seen during FLUSH/RECOVER belong to squashed instructions or bubbles.
    assign stall_o  = (state_q == ST_RUN) ? enc_stall : STALL_NONE;
    assign flush_o  = flush_q;
    assign busy_o   = busy_q;
    assign new_pc_o = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 16'h0;
        end else begin
            if ((state_q == ST_RUN) && (stall_o != STALL_NONE)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (accept && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule
